// File: rtl/blink_period_meter.sv
`timescale 1ns/1ps
// blink_period_meter: measures rise-to-rise period and rise-to-fall high time of a
// 1-pin square wave in clock cycles and flags a stuck input. Glitch filter: BLINK_METER_FILTER_EN.
module blink_period_meter #(
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned TIMEOUT_CYCLES = 32000000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PIN_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             STUCK,
  output logic             LEVEL
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_MEASURE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_src;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_elapsed;
  logic [CNT_W-1:0] w_elapsed_nxt;
  logic [CNT_W-1:0] w_elapsed_inc;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] w_high_nxt;
  logic [CNT_W-1:0] r_high_pend;
  logic [CNT_W-1:0] w_high_pend_nxt;
  logic             r_fall_seen;
  logic             w_fall_seen_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_stuck;
  logic             w_stuck_nxt;

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= PIN_IN;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BLINK_METER_FILTER_EN
  localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FILT_W-1:0] r_filt_cnt;
  logic              r_filt_lvl;

  // Level follows the input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_filt_cnt <= '0;
      r_filt_lvl <= 1'b0;
    end else if (r_sync2 == r_filt_lvl) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
      r_filt_cnt <= '0;
      r_filt_lvl <= r_sync2;
    end else begin
      r_filt_cnt <= r_filt_cnt + FILT_W'(1);
    end
  end

  assign w_src = r_filt_lvl;
`else
  logic w_unused_filt;

  assign w_unused_filt = (FILTER_LEN != 0);
  assign w_src         = r_sync2;
`endif

  // Registered level and edge strobes; strobes coincide with the LEVEL change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_src;
      r_rise  <= w_src & ~r_level;
      r_fall  <= ~w_src & r_level;
    end
  end

  assign w_elapsed_inc = r_elapsed + CNT_W'(1);

  // State and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_elapsed   <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_high_pend <= '0;
      r_fall_seen <= 1'b0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_elapsed   <= w_elapsed_nxt;
      r_period    <= w_period_nxt;
      r_high      <= w_high_nxt;
      r_high_pend <= w_high_pend_nxt;
      r_fall_seen <= w_fall_seen_nxt;
      r_valid     <= w_valid_nxt;
      r_stuck     <= w_stuck_nxt;
    end
  end

  // Next-state: a rise closes a period unless it lands on the timeout cycle (re-arm)
  always_comb begin
    w_state_nxt     = r_state;
    w_period_nxt    = r_period;
    w_high_nxt      = r_high;
    w_high_pend_nxt = r_high_pend;
    w_fall_seen_nxt = r_fall_seen;
    w_valid_nxt     = 1'b0;
    w_stuck_nxt     = r_stuck;
    if (r_rise) begin
      w_elapsed_nxt = '0;
    end else if (r_elapsed < TIMEOUT_C) begin
      w_elapsed_nxt = w_elapsed_inc;
    end else begin
      w_elapsed_nxt = r_elapsed;
    end

    case (r_state)
      S_IDLE: begin
        if (r_rise) begin
          w_state_nxt     = S_MEASURE;
          w_stuck_nxt     = 1'b0;
          w_fall_seen_nxt = 1'b0;
        end
      end
      S_MEASURE: begin
        if (r_rise) begin
          w_fall_seen_nxt = 1'b0;
          if (w_elapsed_inc < TIMEOUT_C) begin
            w_period_nxt = w_elapsed_inc;
            w_high_nxt   = r_fall_seen ? r_high_pend : '0;
            w_valid_nxt  = 1'b1;
          end
        end else if (w_elapsed_inc >= TIMEOUT_C) begin
          w_stuck_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_fall && !r_fall_seen) begin
          w_high_pend_nxt = w_elapsed_inc;
          w_fall_seen_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign PERIOD    = r_period;
  assign HIGH_TIME = r_high;
  assign VALID     = r_valid;
  assign STUCK     = r_stuck;
  assign LEVEL     = r_level;

endmodule

// File: tb/tb_blink_period_meter.sv
`timescale 1ns/1ps
// Scoreboard bench for blink_period_meter: stimulus pushes expected period/high/cycle,
// a VALID monitor pops and compares. Honours BLINK_METER_FILTER_EN.
module tb_blink_period_meter;

  localparam int unsigned CNT_W = 26;
  localparam int unsigned TO    = 1000;
  localparam int unsigned FLEN  = 4;
`ifdef BLINK_METER_FILTER_EN
  localparam int unsigned LAT = 4 + FLEN;
`else
  localparam int unsigned LAT = 4;
`endif

  typedef struct {
    int unsigned period;
    int unsigned high;
    int unsigned vcyc;
  } exp_t;

  logic             CLK    = 1'b0;
  logic             RST_N  = 1'b0;
  logic             PIN_IN = 1'b0;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH_TIME;
  logic             VALID;
  logic             STUCK;
  logic             LEVEL;

  exp_t        exp_q[$];
  int unsigned cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  blink_period_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PIN_IN    (PIN_IN),
    .PERIOD    (PERIOD),
    .HIGH_TIME (HIGH_TIME),
    .VALID     (VALID),
    .STUCK     (STUCK),
    .LEVEL     (LEVEL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Called at the negedge where the closing rise is driven
  task automatic push(input int unsigned p, input int unsigned h);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.vcyc   = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int unsigned n);
    PIN_IN = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic wave(input int unsigned h, input int unsigned p);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " PERIOD"},    32'(PERIOD),    0);
    chk({tag, " HIGH_TIME"}, 32'(HIGH_TIME), 0);
    chk({tag, " VALID"},     32'(VALID),     0);
    chk({tag, " STUCK"},     32'(STUCK),     0);
    chk({tag, " LEVEL"},     32'(LEVEL),     0);
  endtask

  // Monitor: every VALID pulse must match the oldest expectation
  always @(negedge CLK) begin
    if (VALID) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got VALID=1 PERIOD=%0d expected no VALID (cycle %0d)",
                 PERIOD, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.vcyc);
        chk("PERIOD", 32'(PERIOD), e.period);
        chk("HIGH_TIME", 32'(HIGH_TIME), e.high);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N  = 1'b0;
    PIN_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Square wave 100/40: first rise only arms
    wave(40, 100);
    for (int i = 0; i < 4; i++) begin
      push(100, 40);
      wave(40, 100);
    end

    // Hold high after a rise: STUCK after exactly TO cycles past the VALID cycle
    push(100, 40);
    PIN_IN = 1'b1;
    repeat (LAT + TO - 1) @(negedge CLK);
    chk("stuck_before_timeout", 32'(STUCK), 0);
    @(negedge CLK);
    chk("stuck_at_timeout", 32'(STUCK), 1);
    chk("level_when_stuck", 32'(LEVEL), 1);
    chk("period_held", 32'(PERIOD), 100);
    repeat (50) @(negedge CLK);
    hold(1'b0, 20);
    chk("stuck_sticky_after_fall", 32'(STUCK), 1);
    PIN_IN = 1'b1;
    repeat (LAT) @(negedge CLK);
    chk("stuck_cleared_by_rise", 32'(STUCK), 0);
    hold(1'b1, 25 - LAT);
    hold(1'b0, 35);
    push(60, 25);

    // Period 999 measured, period 1000 re-arms without VALID or STUCK
    wave(500, 999);
    push(999, 500);
    wave(10, 1000);
    PIN_IN = 1'b1;
    repeat (LAT) @(negedge CLK);
    chk("stuck_on_rise_timeout_tie", 32'(STUCK), 0);
    chk("period_held_after_rearm", 32'(PERIOD), 999);
    hold(1'b1, 20 - LAT);
    hold(1'b0, 30);
    push(50, 20);

    // 2-cycle low glitch inside the high phase
    hold(1'b1, 30);
    hold(1'b0, 2);
`ifndef BLINK_METER_FILTER_EN
    push(32, 30);
`endif
    hold(1'b1, 8);
    hold(1'b0, 60);
`ifdef BLINK_METER_FILTER_EN
    push(100, 40);
`else
    push(68, 8);
`endif

    // Asynchronous reset mid-period while the input is high
    hold(1'b1, 20);
    #2 RST_N = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    RST_N  = 1'b1;
    PIN_IN = 1'b0;
    repeat (10) @(negedge CLK);
    wave(40, 100);
    push(100, 40);
    wave(30, 100);

    // Constant low from reset: IDLE never times out
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (1100) @(negedge CLK);
    chk("idle_no_stuck_1100", 32'(STUCK), 0);
    repeat (1400) @(negedge CLK);
    chk("idle_no_stuck_2500", 32'(STUCK), 0);
    chk("idle_level", 32'(LEVEL), 0);
    chk("idle_period", 32'(PERIOD), 0);

    chk("missing_valids", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
